i2c_master_tx: RTL and testbench
================================

I2C_MASTER_TX -- requirements
Module: I2C_master_tx

Interface
REQ-001 Parameter: ACK_CHECK, default 1; 1 = NACK forces STOP and ends the transfer, 0 = NACK reported only.
REQ-002 clk  input  1  system clock; one clock, all state on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tx_valid  input  1  host request valid.
REQ-005 tx_ready  output  1  high in IDLE only; request accepted when tx_valid && tx_ready.
REQ-006 tx_data  input  8  byte to send, MSB first; captured at acceptance.
REQ-007 tx_start  input  1  issue START before the byte; captured at acceptance.
REQ-008 tx_stop  input  1  issue STOP after ACK; captured at acceptance.
REQ-009 scl_i  input  1  synchronized SCL.
REQ-010 wr_en, is_data, is_byte, command_i, data_i  output  1 each  control to the write stage.
REQ-011 wr_ld, wr_finish, wr_err, bus_err, sda_rd  input  1 each  status from the write stage; sda_rd is the actual SDA bit seen.
REQ-012 tx_done  output  1  one-cycle pulse at transfer end.
REQ-013 tx_nack  output  1  ACK bit value of the last transfer; valid when tx_done is high.
REQ-014 tx_err  output  1  one-cycle pulse on abort.

Function
REQ-015 FSM states: IDLE, ARM, START, DATA, ACK, STOP, DONE.
REQ-016 IDLE: on acceptance, load shreg<=tx_data, latch flags, go to ARM.
REQ-017 ARM: wait for a cycle with scl_i==0; next state is START if the start flag is set, else DATA.
REQ-018 wr_en is 1 in START/DATA/ACK/STOP and 0 in IDLE/ARM/DONE.
REQ-019 START: is_data=0, command_i=1. On wr_finish go to DATA.
REQ-020 DATA: is_data=1, is_byte=1, data_i=shreg[7]. On wr_ld, shift shreg left by 1 with 1 filled in. On wr_finish go to ACK.
REQ-021 ACK: is_data=1, is_byte=0, data_i=1 (release SDA). Sample sda_rd on wr_ld into the nack flag. On wr_finish: go to STOP if the stop flag is set or (ACK_CHECK && nack); otherwise go to DONE.
REQ-022 STOP: is_data=0, command_i=0. On wr_finish go to DONE.
REQ-023 DONE: one cycle; tx_done=1, tx_nack=nack flag; then go to IDLE.
REQ-024 wr_en stays continuously high across START->DATA->ACK->STOP; phase outputs change in the same cycle the state changes.
REQ-025 Abort: wr_err or bus_err while wr_en=1 -> next state IDLE, tx_err pulses 1 cycle, wr_en drops, no tx_done.
REQ-026 Abort has priority when it occurs in the same cycle as wr_finish.
REQ-027 tx_valid is ignored outside IDLE.
REQ-028 tx_data, tx_start and tx_stop are not re-sampled after acceptance.
REQ-029 Outside their phases: command_i=0, is_data=0, is_byte=0, data_i=1.

Reset
REQ-030 Reset (async, any state including mid-transfer): state=IDLE, shreg=8'hFF, flags=0, nack=0.
REQ-031 Outputs during reset: wr_en=0, data_i=1, tx_ready=1, tx_done=0, tx_err=0, tx_nack=0.
REQ-032 No STOP is generated by reset; recovery of the bus is the host's responsibility.

Structure
REQ-033 A shared package holds the FSM state encoding (3-bit localparams) and the command encoding (1=START, 0=STOP).
REQ-034 One natural sub-module: I2C_tx_shreg (8-bit load/shift-on-wr_ld register). The FSM stays in this module.
REQ-035 The write stage is instantiated beside this block, not inside it.

Verification
REQ-036 tx_data=8'hA5, start=1, stop=1, slave ACKs -> START; SDA bits 1,0,1,0,0,1,0,1; ACK sampled 0; STOP; tx_done=1, tx_nack=0.
REQ-037 tx_data=8'h3C, start=0, stop=0, ACK -> no START/STOP; 8 wr_ld pulses in DATA; tx_done after ACK; wr_en low in DONE.
REQ-038 ACK_CHECK=1, slave NACKs, stop=0 -> STOP still issued; tx_nack=1. With ACK_CHECK=0 -> no STOP; tx_nack=1.
REQ-039 Force SDA low while the block drives bit 3 =1 -> wr_err -> tx_err pulse, state IDLE, tx_ready=1, no tx_done.
REQ-040 Assert rst_n=0 mid-DATA -> wr_en=0, data_i=1, tx_ready=1 immediately; a new request after release runs normally.
REQ-041 tx_valid held high through a transfer -> exactly one acceptance per IDLE visit; the second byte starts only after DONE.

Source files
------------

// File: rtl/i2c_master_tx_pkg.sv
// Shared definitions for the I2C byte-transmit controller: FSM state
// encoding, write-stage command encoding and the shift-register idle value.
package i2c_master_tx_pkg;

    // 3-bit state codes, kept as localparams so other blocks can decode them
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ARM   = ST_ARM,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_ACK   = ST_ACK,
        S_STOP  = ST_STOP,
        S_DONE  = ST_DONE
    } state_e;

    // Write-stage command bit carried on command_i when is_data=0
    localparam logic CMD_START = 1'b1;
    localparam logic CMD_STOP  = 1'b0;

    // Shift register content while idle: all ones keeps SDA released
    localparam logic [7:0] SHREG_IDLE = 8'hFF;

    // States in which the write stage is driven (wr_en high)
    function automatic logic is_bus_phase(input state_e s);
        return (s == S_START) || (s == S_DATA) || (s == S_ACK) || (s == S_STOP);
    endfunction

endpackage

// File: rtl/i2c_master_tx_shreg.sv
// 8-bit transmit shift register: parallel load on acceptance, shifts left
// by one (filling with 1) on each write-stage bit load. MSB is the SDA bit.
module i2c_master_tx_shreg
    import i2c_master_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       shift_i,
    output logic       msb_o
);

    logic [7:0] shreg_q;
    logic [7:0] shreg_d;

    // Load takes precedence over shift; ones shifted in keep SDA released
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = load_data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[6:0], 1'b1};
        end
    end

    // Register with asynchronous return to the released-bus pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= SHREG_IDLE;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[7];

endmodule

// File: rtl/i2c_master_tx.sv
// I2C master byte transmitter: sequences optional START, 8 data bits,
// ACK sampling and optional STOP through an external write stage.
module i2c_master_tx
    import i2c_master_tx_pkg::*;
#(
    parameter bit ACK_CHECK = 1'b1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       tx_stop,
    input  logic       scl_i,
    output logic       wr_en,
    output logic       is_data,
    output logic       is_byte,
    output logic       command_i,
    output logic       data_i,
    input  logic       wr_ld,
    input  logic       wr_finish,
    input  logic       wr_err,
    input  logic       bus_err,
    input  logic       sda_rd,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_err
);

    state_e state_q, state_d;
    logic   start_q, stop_q;
    logic   nack_q, nack_d;
    logic   accept, abort;
    logic   shreg_msb;

    logic   wr_en_q, is_data_q, is_byte_q, cmd_q;
    logic   ready_q, done_q, nack_out_q, err_q;

    // ready_q is high exactly when the FSM sits in IDLE
    assign accept = tx_valid && ready_q;
    // Errors only matter while the write stage is being driven
    assign abort  = wr_en_q && (wr_err || bus_err);

    i2c_master_tx_shreg u_shreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i (tx_data),
        .shift_i     ((state_q == S_DATA) && wr_ld),
        .msb_o       (shreg_msb)
    );

    // Next-state and ACK-flag logic; abort overrides any phase completion
    always_comb begin
        state_d = state_q;
        nack_d  = nack_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ARM;
                    nack_d  = 1'b0;
                end
            end
            S_ARM: begin
                if (!scl_i) begin
                    state_d = start_q ? S_START : S_DATA;
                end
            end
            S_START: begin
                if (wr_finish) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wr_finish) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (wr_ld) begin
                    nack_d = sda_rd;
                end
                if (wr_finish) begin
                    state_d = (stop_q || (ACK_CHECK && nack_d)) ? S_STOP : S_DONE;
                end
            end
            S_STOP: begin
                if (wr_finish) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // FSM register; outputs are decoded from the next state so they move with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            nack_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            is_data_q  <= 1'b0;
            is_byte_q  <= 1'b0;
            cmd_q      <= CMD_STOP;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            nack_out_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nack_q     <= nack_d;
            if (accept) begin
                start_q <= tx_start;
                stop_q  <= tx_stop;
            end
            wr_en_q    <= is_bus_phase(state_d);
            is_data_q  <= (state_d == S_DATA) || (state_d == S_ACK);
            is_byte_q  <= (state_d == S_DATA);
            cmd_q      <= (state_d == S_START) ? CMD_START : CMD_STOP;
            ready_q    <= (state_d == S_IDLE);
            done_q     <= (state_d == S_DONE);
            nack_out_q <= (state_d == S_DONE) && nack_d;
            err_q      <= abort;
        end
    end

    assign wr_en     = wr_en_q;
    assign is_data   = is_data_q;
    assign is_byte   = is_byte_q;
    assign command_i = cmd_q;
    // Only the data phase drives a shifted bit; every other time SDA is released
    assign data_i    = is_byte_q ? shreg_msb : 1'b1;
    assign tx_ready  = ready_q;
    assign tx_done   = done_q;
    assign tx_nack   = nack_out_q;
    assign tx_err    = err_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: two lanes (ACK_CHECK=1 and ACK_CHECK=0), each with
// a host driver, a reactive write-stage responder, a phase-queue model and a
// per-cycle output comparator, plus literal checks on directed transfers.
`timescale 1ns/1ps
module tb_i2c_master_tx;

    localparam int T_IDLE  = 0;
    localparam int T_ARM   = 1;
    localparam int T_START = 2;
    localparam int T_DATA  = 3;
    localparam int T_ACK   = 4;
    localparam int T_STOP  = 5;
    localparam int T_DONE  = 6;
    localparam int N_DIR   = 8;
    localparam int N_RND   = 40;
    localparam int N_ALL   = N_DIR + N_RND;

    typedef struct packed {
        logic [7:0] data;
        logic       start;
        logic       stop;
        logic       nack;
        logic [1:0] err;      // 0 none, 1 wr_err on bit 3, 2 bus_err on bit 3
        logic       rst_mid;
        logic       hold;     // keep tx_valid high with the next item after acceptance
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [7:0] d, input logic s, input logic p,
                                 input logic n, input logic [1:0] e, input logic r,
                                 input logic h);
        item_t it;
        it.data = d; it.start = s; it.stop = p; it.nack = n;
        it.err = e; it.rst_mid = r; it.hold = h;
        return it;
    endfunction

    function automatic item_t dir_item(input int i);
        case (i)
            0:       return mk(8'hA5, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
            1:       return mk(8'h3C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
            2:       return mk(8'h96, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
            3:       return mk(8'h5A, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
            4:       return mk(8'hC3, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
            5:       return mk(8'h81, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
            6:       return mk(8'h11, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
            default: return mk(8'hEE, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        endcase
    endfunction

    function automatic item_t rnd_item();
        item_t it;
        it.data    = 8'($urandom);
        it.start   = 1'($urandom_range(0, 1));
        it.stop    = 1'($urandom_range(0, 1));
        it.nack    = ($urandom_range(0, 2) == 0);
        it.err     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
        it.rst_mid = (it.err == 2'd0) && ($urandom_range(0, 15) == 0);
        it.hold    = !it.rst_mid && ($urandom_range(0, 2) == 0);
        return it;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam bit ACK_CHECK = (g == 0);

        logic       rst_n;
        logic       tx_valid, tx_ready, tx_start, tx_stop, scl_i;
        logic [7:0] tx_data;
        logic       wr_en, is_data, is_byte, command_i, data_i;
        logic       wr_ld, wr_finish, wr_err, bus_err, sda_rd;
        logic       tx_done, tx_nack, tx_err;
        bit         fin = 1'b0;

        logic       plan_nack[$];
        logic [1:0] plan_err[$];

        logic [7:0] obs_bits;
        int         obs_ld;
        bit         saw_start, saw_stop;

        int         q[$];
        logic [7:0] m_data;
        logic       m_stop, m_nack, m_err;
        int         m_ld;

        i2c_master_tx #(.ACK_CHECK(ACK_CHECK)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_valid  (tx_valid),
            .tx_ready  (tx_ready),
            .tx_data   (tx_data),
            .tx_start  (tx_start),
            .tx_stop   (tx_stop),
            .scl_i     (scl_i),
            .wr_en     (wr_en),
            .is_data   (is_data),
            .is_byte   (is_byte),
            .command_i (command_i),
            .data_i    (data_i),
            .wr_ld     (wr_ld),
            .wr_finish (wr_finish),
            .wr_err    (wr_err),
            .bus_err   (bus_err),
            .sda_rd    (sda_rd),
            .tx_done   (tx_done),
            .tx_nack   (tx_nack),
            .tx_err    (tx_err)
        );

        initial begin : scl_drv
            scl_i = 1'b0;
            forever begin
                @(posedge clk);
                #1 scl_i = 1'($urandom_range(0, 1));
            end
        end

        // Write-stage responder: reacts to the phase the DUT presents
        initial begin : wstage
            int ph, prev_ph, cnt;
            wr_ld = 1'b0; wr_finish = 1'b0; wr_err = 1'b0; bus_err = 1'b0; sda_rd = 1'b1;
            prev_ph = T_IDLE; cnt = 0;
            forever begin
                @(posedge clk);
                #1;
                wr_ld = 1'b0; wr_finish = 1'b0; wr_err = 1'b0; bus_err = 1'b0;
                sda_rd = 1'($urandom_range(0, 1));
                if (!rst_n) begin
                    plan_nack.delete(); plan_err.delete();
                    prev_ph = T_IDLE; cnt = 0;
                    continue;
                end
                if (!wr_en)       ph = T_IDLE;
                else if (is_data) ph = is_byte ? T_DATA : T_ACK;
                else              ph = command_i ? T_START : T_STOP;
                if (ph != prev_ph) cnt = 0;
                prev_ph = ph;
                if (ph == T_START) saw_start = 1'b1;
                if (ph == T_STOP)  saw_stop  = 1'b1;
                if (ph == T_IDLE) begin
                    if ($urandom_range(0, 7) == 0)
                        {wr_ld, wr_finish, wr_err, bus_err} = 4'($urandom);
                end else if ($urandom_range(0, 3) != 0) begin
                    case (ph)
                        T_START, T_STOP: wr_finish = 1'b1;
                        T_DATA: begin
                            if (cnt < 8) begin
                                if (plan_err.size() > 0 && plan_err[0] != 2'd0 && cnt == 4) begin
                                    if (plan_err[0] == 2'd1) wr_err = 1'b1;
                                    else                     bus_err = 1'b1;
                                    void'(plan_err.pop_front());
                                    void'(plan_nack.pop_front());
                                end else begin
                                    wr_ld = 1'b1;
                                    obs_bits = {obs_bits[6:0], data_i};
                                    obs_ld++;
                                    cnt++;
                                end
                            end else begin
                                wr_finish = 1'b1;
                            end
                        end
                        default: begin
                            if (cnt == 0) begin
                                wr_ld  = 1'b1;
                                sda_rd = (plan_nack.size() > 0) ? plan_nack[0] : 1'b0;
                                cnt    = 1;
                            end else begin
                                wr_finish = 1'b1;
                                if (plan_nack.size() > 0) begin
                                    void'(plan_nack.pop_front());
                                    void'(plan_err.pop_front());
                                end
                            end
                        end
                    endcase
                end
            end
        end

        // Reference: queue of phases the current transfer still has to pass through
        initial begin : model
            logic e;
            m_data = 8'h00; m_stop = 1'b0; m_nack = 1'b0; m_err = 1'b0; m_ld = 0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    q.delete(); m_nack = 1'b0; m_err = 1'b0; m_ld = 0;
                    continue;
                end
                e = 1'b0;
                if (q.size() == 0) begin
                    if (tx_valid) begin
                        m_data = tx_data; m_stop = tx_stop; m_nack = 1'b0; m_ld = 0;
                        q.push_back(T_ARM);
                        if (tx_start) q.push_back(T_START);
                        q.push_back(T_DATA);
                        q.push_back(T_ACK);
                    end
                end else if (q[0] == T_ARM) begin
                    if (!scl_i) void'(q.pop_front());
                end else if (q[0] == T_DONE) begin
                    void'(q.pop_front());
                end else if (wr_err || bus_err) begin
                    q.delete();
                    e = 1'b1;
                end else begin
                    if (q[0] == T_DATA && wr_ld) m_ld++;
                    if (q[0] == T_ACK && wr_ld)  m_nack = sda_rd;
                    if (wr_finish) begin
                        if (q[0] == T_ACK) begin
                            if (m_stop || (ACK_CHECK && m_nack)) q.push_back(T_STOP);
                            q.push_back(T_DONE);
                        end
                        void'(q.pop_front());
                    end
                end
                m_err = e;
            end
        end

        // Per-cycle comparison of every control output against the model
        initial begin : cmp
            int h;
            logic [8:0] exp_v, act_v;
            forever begin
                @(negedge clk);
                h = (q.size() > 0) ? q[0] : T_IDLE;
                exp_v = {h == T_IDLE, h >= T_START && h <= T_STOP, h == T_DATA || h == T_ACK,
                         h == T_DATA, h == T_START,
                         (h == T_DATA && m_ld < 8) ? m_data[7 - m_ld] : 1'b1,
                         h == T_DONE, m_err, (h == T_DONE) ? m_nack : 1'b0};
                act_v = {tx_ready, wr_en, is_data, is_byte, command_i, data_i,
                         tx_done, tx_err, tx_nack & (h == T_DONE)};
                check($sformatf("lane%0d_outputs(rdy,wen,isd,isb,cmd,dat,done,err,nack)", g),
                      32'(act_v), 32'(exp_v));
            end
        end

        // Host: presents requests, waits for completion, pins directed results
        initial begin : host
            item_t items[N_ALL];
            item_t it, nx;
            bit got;
            rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_start = 1'b0; tx_stop = 1'b0;
            obs_bits = 8'h00; obs_ld = 0; saw_start = 1'b0; saw_stop = 1'b0;
            for (int i = 0; i < N_ALL; i++) items[i] = (i < N_DIR) ? dir_item(i) : rnd_item();
            repeat (3) @(negedge clk);
            check($sformatf("lane%0d_reset_outputs", g),
                  32'({tx_ready, wr_en, data_i, tx_done, tx_err, tx_nack}), 32'(6'b101000));
            #2 rst_n = 1'b1;
            for (int i = 0; i < N_ALL; i++) begin
                it = items[i];
                tx_valid = 1'b1; tx_data = it.data; tx_start = it.start; tx_stop = it.stop;
                got = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    if (tx_ready) begin got = 1'b1; break; end
                    @(negedge clk);
                end
                check($sformatf("lane%0d_accept_item%0d", g, i), 32'(got), 32'd1);
                if (!got) break;
                @(posedge clk);
                plan_nack.push_back(it.nack);
                plan_err.push_back(it.err);
                obs_bits = 8'h00; obs_ld = 0; saw_start = 1'b0; saw_stop = 1'b0;
                #1;
                if (it.hold && i + 1 < N_ALL) begin
                    nx = items[i + 1];
                    tx_data = nx.data; tx_start = nx.start; tx_stop = nx.stop;
                end else begin
                    tx_valid = 1'b0;
                    tx_data = 8'($urandom); tx_start = 1'($urandom); tx_stop = 1'($urandom);
                end
                if (it.rst_mid) begin
                    got = 1'b0;
                    for (int k = 0; k < 200 && !got; k++) begin
                        @(negedge clk);
                        got = is_data && is_byte;
                    end
                    check($sformatf("lane%0d_reach_data_item%0d", g, i), 32'(got), 32'd1);
                    #2 rst_n = 1'b0;
                    #1 check($sformatf("lane%0d_async_reset(wen,dat,rdy)", g),
                             32'({wr_en, data_i, tx_ready}), 32'(3'b011));
                    @(negedge clk);
                    @(negedge clk);
                    #2 rst_n = 1'b1;
                end else begin
                    got = 1'b0;
                    for (int k = 0; k < 400 && !got; k++) begin
                        @(negedge clk);
                        got = tx_done || tx_err;
                    end
                    check($sformatf("lane%0d_end_item%0d", g, i), 32'(got), 32'd1);
                    if (i == 0) begin
                        check($sformatf("lane%0d_A5_bits", g), 32'(obs_bits), 32'h0A5);
                        check($sformatf("lane%0d_A5_start_stop", g), 32'({saw_start, saw_stop}), 32'd3);
                        check($sformatf("lane%0d_A5_done_nack", g), 32'({tx_done, tx_nack}), 32'd2);
                    end else if (i == 1) begin
                        check($sformatf("lane%0d_3C_bits", g), 32'(obs_bits), 32'h03C);
                        check($sformatf("lane%0d_3C_ld_count", g), 32'(obs_ld), 32'd8);
                        check($sformatf("lane%0d_3C_start_stop", g), 32'({saw_start, saw_stop}), 32'd0);
                        check($sformatf("lane%0d_3C_done_wren", g), 32'({tx_done, wr_en}), 32'd2);
                    end else if (i == 2) begin
                        check($sformatf("lane%0d_nack_stop", g), 32'(saw_stop), 32'(ACK_CHECK));
                        check($sformatf("lane%0d_nack_flag", g), 32'({tx_done, tx_nack}), 32'd3);
                    end else if (i == 3) begin
                        check($sformatf("lane%0d_err(err,done,rdy)", g),
                              32'({tx_err, tx_done, tx_ready}), 32'(3'b101));
                        check($sformatf("lane%0d_err_bits_sent", g), 32'(obs_ld), 32'd4);
                    end else if (i == 5) begin
                        check($sformatf("lane%0d_after_reset_bits", g), 32'(obs_bits), 32'h081);
                        check($sformatf("lane%0d_after_reset_done", g), 32'({tx_done, tx_nack}), 32'd2);
                    end else if (i == 6) begin
                        check($sformatf("lane%0d_held1_bits", g), 32'(obs_bits), 32'h011);
                        check($sformatf("lane%0d_held1_start_stop", g), 32'({saw_start, saw_stop}), 32'd1);
                    end else if (i == 7) begin
                        check($sformatf("lane%0d_held2_bits", g), 32'(obs_bits), 32'h0EE);
                        check($sformatf("lane%0d_held2_start_stop", g), 32'({saw_start, saw_stop}), 32'd2);
                    end
                end
            end
            tx_valid = 1'b0;
            repeat (5) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin : main
        bit all_fin;
        all_fin = 1'b0;
        for (int k = 0; k < 60000 && !all_fin; k++) begin
            @(posedge clk);
            all_fin = lane[0].fin && lane[1].fin;
        end
        if (!all_fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL global_timeout: lanes finished=%0b required 11", {lane[1].fin, lane[0].fin});
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
